// File: rtl/wb_result_queue.sv
// Result FIFO between one execution unit and the WriteBack arbiter.
// Presents the oldest result as a request and retires it on a non-stalled cycle.
module wb_result_queue #(
  parameter int DEPTH  = 4,
  parameter int VREG_W = 5,
  parameter int DATA_W = 64,
  parameter int RID_W  = 5,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VREG_W-1:0] in_vreg,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RID_W-1:0]  in_rid,
  output logic              req,
  output logic [VREG_W-1:0] req_vreg,
  output logic [DATA_W-1:0] req_data,
  output logic [RID_W-1:0]  req_rid,
  input  logic              stall,
  output logic [CNT_W-1:0]  count,
  output logic              overflow_err
);

  localparam int ENT_W = VREG_W + DATA_W + RID_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic full, empty;
  logic fire_in, fire_out, we;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = !full;
  assign req      = !empty;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = req && !stall;
  assign we       = fire_in && !flush && !rst;

  assign count        = cnt_q;
  assign overflow_err = ovf_q;

  // Empty queue drives zeros so stale RAM never leaks onto the request bus
  always_comb begin
    req_vreg = '0;
    req_data = '0;
    req_rid  = '0;
    if (!empty) begin
      {req_vreg, req_data, req_rid} = mem_q[rd_q];
    end
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | (in_valid && full);
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (fire_in) begin
        wr_d = wr_q + PTR_W'(1);
      end
      if (fire_out) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(fire_in) - CNT_W'(fire_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_q] <= {in_vreg, in_data, in_rid};
    end
  end

endmodule

// File: tb/tb_wb_result_queue.sv
// Bench for wb_result_queue: directed plan steps plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_wb_result_queue;

  localparam int DEPTH  = 4;
  localparam int VREG_W = 5;
  localparam int DATA_W = 64;
  localparam int RID_W  = 5;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, req, stall, overflow_err;
  logic [VREG_W-1:0] in_vreg, req_vreg;
  logic [DATA_W-1:0] in_data, req_data;
  logic [RID_W-1:0]  in_rid, req_rid;
  logic [CNT_W-1:0]  count;

  always #5 clk = ~clk;

  wb_result_queue #(
    .DEPTH(DEPTH), .VREG_W(VREG_W), .DATA_W(DATA_W), .RID_W(RID_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vreg(in_vreg), .in_data(in_data), .in_rid(in_rid),
    .req(req), .req_vreg(req_vreg), .req_data(req_data), .req_rid(req_rid),
    .stall(stall), .count(count), .overflow_err(overflow_err)
  );

  typedef struct packed {
    logic [VREG_W-1:0] vreg;
    logic [DATA_W-1:0] data;
    logic [RID_W-1:0]  rid;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ctx);
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk({ctx, ".req"},   64'(req),          64'(mq.size() != 0));
    chk({ctx, ".rdy"},   64'(in_ready),     64'(mq.size() < DEPTH));
    chk({ctx, ".count"}, 64'(count),        64'(mq.size()));
    chk({ctx, ".ovf"},   64'(overflow_err), 64'(m_ovf));
    chk({ctx, ".rid"},   64'(req_rid),      64'(h.rid));
    chk({ctx, ".vreg"},  64'(req_vreg),     64'(h.vreg));
    chk({ctx, ".data"},  req_data,          h.data);
  endtask

  // Inputs applied 1ns after an edge; outputs checked, then one edge taken
  task automatic step(bit v, bit s, bit f, bit r, int rid, int vr,
                      logic [DATA_W-1:0] d, string ctx);
    ent_t e;
    bit   full, pop, push;
    in_valid = v; stall = s; flush = f; rst = r;
    in_rid = RID_W'(rid); in_vreg = VREG_W'(vr); in_data = d;
    check_all(ctx);
    e = '{vreg: VREG_W'(vr), data: d, rid: RID_W'(rid)};
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      full = (mq.size() == DEPTH);
      pop  = (mq.size() != 0) && !s;
      push = v && !full;
      if (v && full) m_ovf = 1;
      if (f) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(e);
      end
    end
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [DATA_W-1:0] a5;
    a5 = {8{8'hA5}};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    in_rid = '0; in_vreg = '0; in_data = '0;
    m_ovf = 0;
    @(posedge clk); #1;

    // reset state
    step(0, 0, 0, 1, 0, 0, 0, "rst1");
    step(0, 0, 0, 0, 0, 0, 0, "rst2");
    chk("rst.count0", 64'(count), 64'd0);
    chk("rst.rdy1",   64'(in_ready), 64'd1);

    // single pass
    step(1, 0, 0, 0, 1, 3, a5, "single.push");
    chk("single.req", 64'(req), 64'd1);
    chk("single.rid", 64'(req_rid), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, "single.pop");
    step(0, 0, 0, 0, 0, 0, 0, "single.idle");

    // fill under stall, overflow attempt, head stable
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, i, i + 8, rnd64(), "fill");
    chk("fill.count4", 64'(count), 64'd4);
    chk("fill.rdy0",   64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 4, 12, rnd64(), "ovf");
    chk("ovf.sticky", 64'(overflow_err), 64'd1);
    chk("ovf.head0",  64'(req_rid), 64'd0);

    // drain with one stall mid-way
    step(0, 0, 0, 0, 0, 0, 0, "drain0");
    step(0, 1, 0, 0, 0, 0, 0, "drain1s");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, "drain");
    chk("drain.empty", 64'(req), 64'd0);

    // preload two, then sustained push/pop across wrap
    step(1, 1, 0, 0, 20, 1, rnd64(), "pre");
    step(1, 1, 0, 0, 21, 2, rnd64(), "pre");
    for (int i = 5; i < 15; i++) step(1, 0, 0, 0, i, i, rnd64(), "wrap");
    chk("wrap.count2", 64'(count), 64'd2);
    chk("wrap.head13", 64'(req_rid), 64'd13);

    // flush with simultaneous push
    step(1, 1, 0, 0, 15, 4, rnd64(), "pre3");
    step(1, 1, 1, 0, 16, 5, rnd64(), "flush");
    chk("flush.count0", 64'(count), 64'd0);
    chk("flush.ovfkept", 64'(overflow_err), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, "postflush");

    // reset mid-operation
    step(1, 1, 0, 0, 17, 6, rnd64(), "refill");
    step(1, 1, 0, 0, 18, 7, rnd64(), "refill");
    step(1, 1, 0, 1, 19, 8, rnd64(), "midrst");
    chk("midrst.ovf0", 64'(overflow_err), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, "postrst");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           rnd64(), "rand");
    end
    step(0, 0, 0, 0, 0, 0, 0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_result_queue.md
Name: wb_result_queue

Overview:
- Per-execution-unit result buffer sitting directly upstream of the WriteBack arbiter; one instance per request channel.
- Accepts completed results (vector data, destination vreg index, reservation ID) from an execution unit through a valid/ready handshake.
- Queues results in FIFO order and presents the oldest one to WriteBack as a request.
- Retires the head entry only in a cycle where WriteBack does not stall this channel.

Parameters:
- DEPTH, 4, number of result entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all queued entries.
- in_valid  input  1  execution unit presents a result this cycle.
- in_ready  output  1  queue can accept a result this cycle.
- in_vreg  input  VRegIdx_t  destination vector register index.
- in_data  input  Vector_t  result vector.
- in_rid  input  RsvID_t  reservation-station ID of the producing instruction.
- req  output  1  head entry valid; drives this channel's bit of WriteBack reqs.
- req_vreg  output  VRegIdx_t  head entry vreg index; drives reqVRegIdx[ch].
- req_data  output  Vector_t  head entry data; drives reqDataVecs[ch].
- req_rid  output  RsvID_t  head entry RID; drives reqRID[ch].
- stall  input  1  this channel's bit of WriteBack stallVec.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow_err  output  1  sticky; set when a push is attempted while full.

Behaviour:
- Storage and pointers:
  - Circular buffer with rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
  - count tracks occupancy explicitly; full = (count == DEPTH), empty = (count == 0).
- Push (fire_in):
  - fire_in = in_valid && in_ready.
  - Writes {in_vreg, in_data, in_rid} at wr_ptr, then wr_ptr++.
- Ready:
  - in_ready = !full.
  - Purely a function of registered count. No combinational path from stall or req to in_ready.
  - When full, no push is accepted even if a pop occurs in the same cycle.
- Request outputs:
  - req = !empty.
  - req_vreg, req_data and req_rid are the head entry read combinationally at rd_ptr.
  - When empty, these three outputs are held at 0.
- Pop (fire_out):
  - fire_out = req && !stall; then rd_ptr++.
  - When req=1 and stall=1, head outputs stay bit-stable into the next cycle.
- Latency:
  - No bypass. A result pushed in cycle N appears on req at cycle N+1 at the earliest.
  - Sustained throughput is 1 result/cycle when stall=0 and count<DEPTH.
- Simultaneous push and pop (count in 1..DEPTH-1): both pointers advance and count is unchanged.
- Count update: count_next = count + fire_in - fire_out.
- Order: strict FIFO. Entry k is never presented before entry k-1 has retired.
- Overflow:
  - in_valid=1 while full is dropped and sets overflow_err=1.
  - overflow_err is cleared only by rst; flush does not clear it.
- Flush:
  - rd_ptr, wr_ptr and count are set to 0 at the next edge, so req=0 the following cycle.
  - A push in the same cycle as flush is discarded.
  - A pop in the same cycle as flush has no additional effect.
  - in_ready is unaffected by flush during the flush cycle itself.
- Reset:
  - rst=1 at a clock edge sets rd_ptr=0, wr_ptr=0, count=0, overflow_err=0.
  - Resulting outputs: req=0, in_ready=1, req_* = 0.
  - rst overrides flush, push and pop. Data RAM contents need not be cleared.
  - Reset asserted mid-operation (entries queued, stall active) discards all entries. No request from before reset may reappear.
- Stall while empty:
  - WriteBack drives stall=0 when it has no requests.
  - The queue ignores stall whenever req=0.

Test Plan (DEPTH=4):
- Reset state: hold rst 2 cycles -> req=0, in_ready=1, count=0, overflow_err=0, req_* = 0.
- Single pass, stall=0:
  - Stimulus: push {vreg=3, rid=1, data=0xA5..}.
  - Response: req=1 in the next cycle with those values; req=0 one cycle later; count returns to 0.
- Fill and backpressure, stall=1:
  - Stimulus: push 4 entries rid=0..3, then hold in_valid with rid=4.
  - Response: count=4, in_ready=0, rid=4 dropped, overflow_err=1, req_rid=0 stable over 5 stalled cycles.
- Drain order:
  - Stimulus: from full, drop stall.
  - Response: req_rid sequence 0,1,2,3 on consecutive cycles, then req=0.
  - Inject one stall=1 cycle mid-drain -> the current rid repeats exactly one extra cycle.
- Simultaneous push/pop with wrap:
  - Stimulus: count=2, stall=0, in_valid=1 for 10 cycles with rid=5..14.
  - Response: count stays 2; rids retire in order 5..12 across pointer wrap.
- Flush and reset mid-operation:
  - Flush stimulus: count=3, assert flush together with in_valid=1.
  - Flush response: next cycle count=0, req=0, pushed entry absent; overflow_err unchanged.
  - Reset stimulus: refill 2 entries, assert rst with stall=1.
  - Reset response: next cycle req=0, count=0, overflow_err=0.
